// File: rtl/register_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one debug read port, one synchronous write port, $zero hardwired to zero.
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h0000_1800,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_3FFC,
    parameter int                    BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int N_PORTS = 3;
    localparam int DBG_PORT = 2;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr [N_PORTS];
    logic [DATA_WIDTH-1:0] rd_data [N_PORTS];
    logic                  bypass_en;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
        case (idx)
            28:      return GP_INIT;
            29:      return SP_INIT;
            default: return '0;
        endcase
    endfunction

    // Index 0 is never written, so its storage keeps the reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= reset_value(i);
            end
        end else if (reg_write && (write_reg != '0)) begin
            regs_reg[write_reg] <= write_data;
        end
    end

    // Forwarding is suppressed during reset so reads show reset contents.
    assign bypass_en = reg_write & ~rst;

    assign rd_addr = '{read_reg1, read_reg2, dbg_addr};

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_read
            localparam bit CAN_BYPASS = (BYPASS != 0) && (gi != DBG_PORT);

            assign rd_data[gi] =
                (rd_addr[gi] == '0)                                     ? '0 :
                (CAN_BYPASS && bypass_en && (rd_addr[gi] == write_reg)) ? write_data :
                                                                          regs_reg[rd_addr[gi]];
        end
    endgenerate

    assign read_data1 = rd_data[0];
    assign read_data2 = rd_data[1];
    assign dbg_data   = rd_data[DBG_PORT];

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry general-purpose register file of the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit RegDst destination mux: its write address port takes that mux output, which selects between rt and rd.
- Two asynchronous read ports feed the ALU operand path and the store-data path.
- One synchronous write port takes the write-back value.
- $zero is hardwired to zero; $gp and $sp have reset values set by parameters.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width (depth = 2**ADDR_WIDTH = 32)
GP_INIT, 32'h0000_1800, value loaded into register 28 ($gp) on reset
SP_INIT, 32'h0000_3FFC, value loaded into register 29 ($sp) on reset
BYPASS, 0, 1 = a read of the register being written this cycle returns write_data; 0 = returns stored value

Ports:
clk  input  1  system clock; all writes occur on the rising edge
rst  input  1  asynchronous, active-high reset
reg_write  input  1  write enable from the control unit
read_reg1  input  ADDR_WIDTH  read port 1 index (instr[25:21], rs)
read_reg2  input  ADDR_WIDTH  read port 2 index (instr[20:16], rt)
write_reg  input  ADDR_WIDTH  destination index from the RegDst mux
write_data  input  DATA_WIDTH  write-back value (ALU result or memory data)
read_data1  output  DATA_WIDTH  contents of read_reg1
read_data2  output  DATA_WIDTH  contents of read_reg2
dbg_addr  input  ADDR_WIDTH  debug/testbench read index
dbg_data  output  DATA_WIDTH  contents of dbg_addr (never bypassed)

Behaviour:
- Storage: 32 x DATA_WIDTH flip-flop array.
- Reset:
  - rst high asynchronously clears every entry to 0, except entry 28 = GP_INIT and entry 29 = SP_INIT.
  - While rst is high, writes are blocked.
  - Reset asserted mid-cycle overrides any write pending on that edge.
  - Deassertion has no effect until the next rising clk.
- Write:
  - On rising clk with rst low and reg_write = 1, entry[write_reg] <= write_data.
  - Write latency is 1 cycle: the new value is visible on the read ports after that edge.
  - reg_write = 0: no entry changes, whatever write_reg and write_data hold.
- Register 0:
  - A write to index 0 is silently discarded; entry 0 stays 0.
  - Reads of index 0 return 0 on every port, including when BYPASS = 1 and write_reg = 0.
- Reads:
  - Purely combinational from the address inputs and array contents; zero-cycle latency.
  - read_data1 and read_data2 are independent; identical indices return identical data.
  - All read outputs reflect reset contents while rst is high.
- Simultaneous read/write of the same nonzero index in one cycle:
  - BYPASS = 0: the read port shows the old value until the edge, then the new value.
  - BYPASS = 1: the read port shows write_data combinationally while reg_write = 1 and the indices match.
  - The dbg port always shows the stored value.
- No other state; no handshake; every cycle is valid.
- Unknown (X) values on write_reg while reg_write = 0 must not corrupt any entry.
- Width rules:
  - No arithmetic; data stored unmodified at full DATA_WIDTH.
  - Indices are used unsigned with no wrap logic, since all 2**ADDR_WIDTH indices are valid.

Test Plan:
- Reset check: pulse rst mid-cycle, sweep dbg_addr 0..31 -> 0 everywhere except dbg_data = 32'h0000_1800 at 28 and 32'h0000_3FFC at 29; read_data1/2 match.
- Basic write/read: reg_write = 1, write_reg = 8, write_data = 32'hDEAD_BEEF, one edge; then read_reg1 = 8 and read_reg2 = 8 -> both 32'hDEAD_BEEF; entry 9 stays 0.
- $zero protection: write 32'hFFFF_FFFF to index 0, with BYPASS = 0 and with BYPASS = 1 -> read_data1 = 0 before and after the edge.
- Write enable gating: reg_write = 0, write_reg = 17, write_data = 32'h1234_5678, 3 edges -> entry 17 still 0.
- Same-cycle read/write on index 5, holding 32'h11 and writing 32'h22:
  - BYPASS = 0 -> read_data2 = 32'h11 before the edge, 32'h22 after.
  - BYPASS = 1 -> read_data2 = 32'h22 before the edge.
  - dbg_data = 32'h11 before the edge in both cases.
- Reset mid-operation: write 32'hA5A5_A5A5 to 29, assert rst coincident with a second write of 32'h5A5A_5A5A to 29 -> entry 29 = 32'h0000_3FFC; after deassert, a write of 32'h7 lands on the next edge.
